div_iter_param: RTL and testbench

- Parametrised iterative restoring divider for the integer pipeline.
- Generalises the fixed 32-bit divider in four ways:
  - WIDTH-bit operands.
  - Leading-zero early termination at configurable granularity, replacing the fixed 16/24/28-bit shortcuts.
  - Defined divide-by-zero handling with a flag.
  - valid/ready handshakes on both input and output, so the result is held until the consumer takes it.
- Sits beside the multiplier in the execute stage. Commit drives flush.

---
 rtl/div_iter_param.sv | 227 ++++++++++++++++++++++
 tb/tb_div_iter_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter_param.sv
// ---------------------------------------------------------------------------
// div_iter_param
// Iterative restoring divider for the execute stage of the integer pipeline.
// It produces one quotient bit per clock. Before the loop starts, the
// dividend is left-aligned so that only its significant bits are iterated.
// The iteration count is rounded up to a multiple of GRAN. Divide-by-zero
// gives a defined result and raises the dbz flag.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   flush      synchronous abort from Commit; next state is IDLE
//   in_valid   operands valid           in_ready  divider can accept (IDLE)
//   a, b       dividend / divisor       signed_en 1 = two's-complement divide
//   out_valid  result valid, held       out_ready consumer takes result
//   q, rem     quotient / remainder     dbz       divide-by-zero flag
//   busy       high in CALC or DONE
// ---------------------------------------------------------------------------
module div_iter_param #(
   parameter int WIDTH = 32,
   parameter int GRAN  = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rem,
   output logic             dbz,
   output logic             busy
);

   localparam int               CW   = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [CW-1:0]    CNT1 = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement negate when neg is set, otherwise pass through.
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x,
                                               input logic             neg);
      logic [WIDTH-1:0] r;
      if (neg) begin
         r = ~x + ONE;
      end else begin
         r = x;
      end
      return r;
   endfunction

   // Iteration count: MSB position + 1, rounded up to a multiple of GRAN.
   function automatic logic [CW-1:0] iter_count(input logic [WIDTH-1:0] x);
      int l;
      l = 0;
      for (int i = 0; i < WIDTH; i++) begin
         l = x[i] ? (i + 1) : l;
      end
      return CW'(((l + GRAN - 1) / GRAN) * GRAN);
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;          // aligned dividend, shifted out MSB first
   logic [WIDTH-1:0] dvs_q, dvs_d;          // divisor magnitude
   logic [WIDTH-1:0] prem_q, prem_d;        // partial remainder (always < divisor)
   logic [WIDTH-1:0] quo_q, quo_d;          // quotient magnitude being built
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;
   logic [WIDTH-1:0] rem_out_q, rem_out_d;
   logic             dbz_q, dbz_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] mag_a_s, mag_b_s, align_s;
   logic [CW-1:0]    n_s;
   logic [WIDTH:0]   rem_shift_s, diff_s;
   logic             qbit_s;
   logic [WIDTH-1:0] prem_next_s, quo_next_s;

   assign mag_a_s = neg_if(a, signed_en & a[WIDTH-1]);
   assign mag_b_s = neg_if(b, signed_en & b[WIDTH-1]);
   assign n_s     = iter_count(mag_a_s);
   // Leading zeros beyond the rounded count are skipped by pre-shifting.
   assign align_s = mag_a_s << (CW'(WIDTH) - n_s);

   // One restoring step. A clear borrow (bit WIDTH) means the divisor fits.
   assign rem_shift_s = {prem_q, dvd_q[WIDTH-1]};
   assign diff_s      = rem_shift_s - {1'b0, dvs_q};
   assign qbit_s      = ~diff_s[WIDTH];
   assign prem_next_s = qbit_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
   assign quo_next_s  = {quo_q[WIDTH-2:0], qbit_s};

   // Next-state and registered-output logic for the IDLE/CALC/DONE FSM.
   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      prem_d      = prem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      q_neg_d     = q_neg_q;
      rem_neg_d   = rem_neg_q;
      q_out_d     = q_out_q;
      rem_out_d   = rem_out_q;
      dbz_d       = dbz_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               q_neg_d   = signed_en & (a[WIDTH-1] ^ b[WIDTH-1]);
               rem_neg_d = signed_en & a[WIDTH-1];
               dvs_d     = mag_b_s;
               prem_d    = ZERO;
               quo_d     = ZERO;
               if (b == ZERO) begin
                  q_out_d   = {WIDTH{1'b1}};
                  rem_out_d = a;
                  dbz_d     = 1'b1;
                  dvd_d     = mag_a_s;
                  cnt_d     = {CW{1'b0}};
                  state_d   = DONE;
               end else if (mag_a_s == ZERO) begin
                  q_out_d   = ZERO;
                  rem_out_d = ZERO;
                  dbz_d     = 1'b0;
                  dvd_d     = ZERO;
                  cnt_d     = {CW{1'b0}};
                  state_d   = DONE;
               end else begin
                  dvd_d     = align_s;
                  cnt_d     = n_s;
                  state_d   = CALC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
               prem_d = prem_next_s;
               quo_d  = quo_next_s;
               cnt_d  = cnt_q - CNT1;
               if (cnt_q == CNT1) begin
                  q_out_d   = neg_if(quo_next_s, q_neg_q);
                  rem_out_d = neg_if(prem_next_s, rem_neg_q);
                  dbz_d     = 1'b0;
                  state_d   = DONE;
               end else begin
                  state_d   = CALC;
               end
            end
         end
         DONE: begin
            // A transfer in the flush cycle still counts; both lead to IDLE.
            if (flush || out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         dvd_q       <= ZERO;
         dvs_q       <= ZERO;
         prem_q      <= ZERO;
         quo_q       <= ZERO;
         cnt_q       <= {CW{1'b0}};
         q_neg_q     <= 1'b0;
         rem_neg_q   <= 1'b0;
         q_out_q     <= ZERO;
         rem_out_q   <= ZERO;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         prem_q      <= prem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         q_neg_q     <= q_neg_d;
         rem_neg_q   <= rem_neg_d;
         q_out_q     <= q_out_d;
         rem_out_q   <= rem_out_d;
         dbz_q       <= dbz_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign q         = q_out_q;
   assign rem       = rem_out_q;
   assign dbz       = dbz_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_div_iter_param.sv
// ---------------------------------------------------------------------------
// tb_div_iter_param
// Directed bench for div_iter_param with WIDTH=32 and GRAN=4. The expected
// values are worked out by hand. Inputs change 1 time unit after the rising
// edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_div_iter_param;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        signed_en;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] q;
   logic [31:0] rem;
   logic        dbz;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   div_iter_param #(.WIDTH(32), .GRAN(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .signed_en (signed_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .rem       (rem),
      .dbz       (dbz),
      .busy      (busy)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation. Then wait, up to a bounded number of cycles, for
   // out_valid, and check the latency and the result. The result is left
   // held, not consumed.
   task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic sv, input int exp_lat, input logic [31:0] exp_q,
                      input logic [31:0] exp_r, input logic exp_dbz);
      int lat;
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      a = av; b = bv; signed_en = sv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0000; signed_en = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         tick();
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".q"}, q, exp_q);
      check({tag, ".rem"}, rem, exp_r);
      check({tag, ".dbz"}, {31'd0, dbz}, {31'd0, exp_dbz});
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".drop_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".idle"}, {30'd0, in_ready, busy}, 32'd2);
   endtask

   initial begin
      int seen;
      logic [31:0] held_q;
      logic [31:0] held_r;
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = 32'd0; b = 32'd0; signed_en = 1'b0;
      #12;
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.q", q, 32'd0);
      check("rst.rem", rem, 32'd0);
      check("rst.dbz_busy", {30'd0, dbz, busy}, 32'd0);
      resetn = 1'b1;
      tick();
      check("rst.in_ready", {31'd0, in_ready}, 32'd1);

      // 100/7: L=7, N=8, latency 9.
      run("u100_7", 32'd100, 32'd7, 1'b0, 9, 32'd14, 32'd2, 1'b0);

      // Backpressure: the result is held and new operands are ignored.
      held_q = q; held_r = rem;
      a = 32'd5; b = 32'd1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp.q", q, 32'd14);
         check("bp.rem", rem, 32'd2);
         check("bp.flags", {29'd0, out_valid, in_ready, busy}, 32'b101);
      end
      in_valid = 1'b0;
      consume("bp");

      // Signed -7/2 -> q=-3, rem=-1 (N=4); unsigned -> N=32.
      run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      consume("s_m7_2");
      run("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
      consume("u_m7_2");

      // Divide by zero, then zero dividend.
      run("dbz", 32'h1234_5678, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      consume("dbz");
      run("zero_a", 32'd0, 32'd5, 1'b0, 1, 32'd0, 32'd0, 1'b0);
      consume("zero_a");

      // Signed overflow: most-negative / -1.
      run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0);
      consume("ovf");

      // Flush on the 3rd CALC cycle of 100/7.
      a = 32'd100; b = 32'd7; signed_en = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush.state", {29'd0, out_valid, in_ready, busy}, 32'b010);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen + (out_valid ? 1 : 0);
      end
      check("flush.no_valid", 32'(seen), 32'd0);
      // 1000/10: L=10, N=12.
      run("u1000_10", 32'd1000, 32'd10, 1'b0, 13, 32'd100, 32'd0, 1'b0);

      // Flush while the result is held drops it.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_done.state", {29'd0, out_valid, in_ready, busy}, 32'b010);
      check("flush_done.q_kept", q, 32'd100);

      // Flush in the same cycle as in_valid: the operation is not accepted.
      a = 32'd9; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      check("flush_acc.state", {29'd0, out_valid, in_ready, busy}, 32'b010);

      // Asynchronous reset mid-CALC clears outputs before the next edge.
      a = 32'd100; b = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2;
      resetn = 1'b0;
      #1;
      check("arst.q", q, 32'd0);
      check("arst.rem", rem, 32'd0);
      check("arst.flags", {29'd0, out_valid, dbz, busy}, 32'd0);
      #2;
      resetn = 1'b1;
      tick();
      // 200/9: L=8, N=8.
      run("u200_9", 32'd200, 32'd9, 1'b0, 9, 32'd22, 32'd2, 1'b0);
      consume("u200_9");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
